// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite load/store master: response codes,
// access size encodings, controller state enum and the alignment rule.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AWW  = 3'd3,
    B    = 3'd4,
    RSP  = 3'd5
  } lsu_state_t;

  // Size 3 has no legal encoding, so it is rejected like a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/axil_lsu_align.sv
// Byte-lane steering for the load/store master: store data replication with
// matching strobes, and load data extraction with sign/zero extension.
module axil_lsu_align
  import axil_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = bus_rdata >> {offset, 3'b000};
    bus_wdata = store_data;
    bus_wstrb = 4'b1111;
    load_data = shifted;
    case (size)
      SIZE_BYTE: begin
        bus_wdata = {4{store_data[7:0]}};
        bus_wstrb = 4'b0001 << offset;
        load_data = {{24{load_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        bus_wdata = {2{store_data[15:0]}};
        bus_wstrb = 4'b0011 << offset;
        load_data = {{16{load_signed & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axil_lsu_master.sv
// Single-outstanding AXI4-Lite master that turns core load/store requests
// into AR/R or AW/W/B transactions and returns one response per request.
//
//   state | meaning
//   IDLE  | ready for a core request
//   AR    | read address presented, waiting for arready
//   R     | rready high, waiting for read data
//   AWW   | write address and data presented, each dropped after its handshake
//   B     | bready high, waiting for write response
//   RSP   | response held to the core until rsp_ready
module axil_lsu_master
  import axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,

  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  lsu_state_t        state_q, state_d;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              aw_done, w_done;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [31:0]       load_data;
  logic              req_fire;
  logic              rsp_capture;

  axil_lsu_align u_align (
    .size        (size_q),
    .load_signed (signed_q),
    .offset      (addr_q[1:0]),
    .store_data  (wdata_q),
    .bus_rdata   (rdata),
    .bus_wdata   (wdata),
    .bus_wstrb   (wstrb),
    .load_data   (load_data)
  );

  assign req_fire    = req_valid && (state_q == IDLE);
  assign rsp_capture = ((state_q == R) && rvalid) || ((state_q == B) && bvalid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SIZE_BYTE;
      signed_q    <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        wen_q       <= req_wen;
        addr_q      <= req_addr;
        wdata_q     <= req_wdata;
        size_q      <= req_size;
        signed_q    <= req_signed;
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        rsp_rdata_q <= '0;
        rsp_err_q   <= misaligned(req_size, req_addr[1:0]);
      end
      if (state_q == AWW) begin
        if (awready) aw_done <= 1'b1;
        if (wready)  w_done  <= 1'b1;
      end
      // A store always returns zero data; only the response code matters.
      if (rsp_capture) begin
        rsp_rdata_q <= wen_q ? '0 : load_data;
        rsp_err_q   <= (wen_q ? bresp : rresp) != RESP_OKAY;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned(req_size, req_addr[1:0])) state_d = RSP;
          else if (req_wen)                        state_d = AWW;
          else                                     state_d = AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_d = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_d = RSP;
      end
      AWW: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_d = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
